cp0_unit: RTL and testbench

// - Coprocessor 0 for the P7 pipeline. Executes the mtc0/mfc0/eret/exception side of the decoder's CP0 interface.
// - Sits in stage M. Holds SR(12), Cause(13), EPC(14) and PRId(15).
// - Arbitrates hardware interrupts against stage-M exceptions and raises req to flush the pipeline and redirect fetch to the handler.

---
 rtl/cp0_unit_pkg.sv | 56 +++++
 rtl/cp0_unit_if.sv | 30 +++
 rtl/cp0_unit.sv | 83 ++++++++
 tb/tb_cp0_unit.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/cp0_unit_pkg.sv
// CP0 shared constants: register numbers, ExcCodes and SR/Cause field layout.
// Also holds packed views of SR and Cause plus their read-word helpers.
package cp0_unit_pkg;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   localparam logic [4:0] EXC_AdEL  = 5'd4;
   localparam logic [4:0] EXC_AdES  = 5'd5;
   localparam logic [4:0] EXC_RI    = 5'd10;
   localparam logic [4:0] EXC_Ov    = 5'd12;

   localparam int SR_IE       = 0;
   localparam int SR_EXL      = 1;
   localparam int SR_IM_LO    = 10;
   localparam int SR_IM_HI    = 15;

   localparam int CAUSE_EXC_LO = 2;
   localparam int CAUSE_EXC_HI = 6;
   localparam int CAUSE_IP_LO  = 10;
   localparam int CAUSE_IP_HI  = 15;
   localparam int CAUSE_BD     = 31;

   typedef struct packed {
      logic [5:0] im;
      logic       exl;
      logic       ie;
   } sr_t;

   typedef struct packed {
      logic       bd;
      logic [5:0] ip;
      logic [4:0] exc;
   } cause_t;

   function automatic logic [31:0] sr_word(input sr_t s);
      logic [31:0] w;
      w = '0;
      w[SR_IM_HI:SR_IM_LO] = s.im;
      w[SR_EXL]            = s.exl;
      w[SR_IE]             = s.ie;
      return w;
   endfunction

   function automatic logic [31:0] cause_word(input cause_t c);
      logic [31:0] w;
      w = '0;
      w[CAUSE_BD]                  = c.bd;
      w[CAUSE_IP_HI:CAUSE_IP_LO]   = c.ip;
      w[CAUSE_EXC_HI:CAUSE_EXC_LO] = c.exc;
      return w;
   endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// Stage-M side of the CP0 port: mtc0/mfc0, exception report, eret and request.
// master = pipeline, slave = cp0_unit.
interface cp0_unit_if;

   logic        cp0_we;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic [31:0] vpc;
   logic        bd_in;
   logic        exc_valid;
   logic [4:0]  exc_code_in;
   logic [5:0]  hw_int;
   logic        exl_clr;
   logic [31:0] cp0_rdata;
   logic [31:0] epc_out;
   logic        req;

   modport master (
      output cp0_we, cp0_addr, cp0_wdata, vpc, bd_in,
      output exc_valid, exc_code_in, hw_int, exl_clr,
      input  cp0_rdata, epc_out, req
   );

   modport slave (
      input  cp0_we, cp0_addr, cp0_wdata, vpc, bd_in,
      input  exc_valid, exc_code_in, hw_int, exl_clr,
      output cp0_rdata, epc_out, req
   );

endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0 in stage M: SR, Cause, EPC, PRId, interrupt/exception arbitration.
// req flushes the pipe and redirects fetch; EXL masks everything until eret.
module cp0_unit
   import cp0_unit_pkg::*;
#(
   parameter logic [31:0] PRID    = 32'h2021_0007,
   parameter logic [4:0]  EXC_INT = 5'd0
) (
   input  logic     clk,
   input  logic     reset,
   cp0_unit_if.slave bus
);

   sr_t         sr_q, sr_d;
   cause_t      cause_q, cause_d;
   logic [31:0] epc_q, epc_d;

   logic        int_req;
   logic        exc_req;
   logic        take;

   always_comb begin
      int_req = (|(bus.hw_int & sr_q.im)) & sr_q.ie & ~sr_q.exl;
      exc_req = bus.exc_valid & ~sr_q.exl;
      take    = int_req | exc_req;
   end

   assign bus.req     = take & ~reset;
   assign bus.epc_out = epc_q;

   always_comb begin
      sr_d     = sr_q;
      cause_d  = cause_q;
      epc_d    = epc_q;
      cause_d.ip = bus.hw_int;
      if (take) begin
         // interrupt outranks a same-cycle exception
         sr_d.exl    = 1'b1;
         cause_d.exc = int_req ? EXC_INT : bus.exc_code_in;
         cause_d.bd  = bus.bd_in;
         epc_d       = bus.bd_in ? bus.vpc - 32'd4 : bus.vpc;
      end else begin
         if (bus.cp0_we) begin
            case (bus.cp0_addr)
               CP0_SR: begin
                  sr_d.im  = bus.cp0_wdata[SR_IM_HI:SR_IM_LO];
                  sr_d.exl = bus.cp0_wdata[SR_EXL];
                  sr_d.ie  = bus.cp0_wdata[SR_IE];
               end
               CP0_EPC: epc_d = bus.cp0_wdata;
               default: ;
            endcase
         end
         // eret lands after a coincident mtc0 to SR
         if (bus.exl_clr) begin
            sr_d.exl = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q    <= '0;
         cause_q <= '0;
         epc_q   <= '0;
      end else begin
         sr_q    <= sr_d;
         cause_q <= cause_d;
         epc_q   <= epc_d;
      end
   end

   always_comb begin
      case (bus.cp0_addr)
         CP0_SR:    bus.cp0_rdata = sr_word(sr_q);
         CP0_CAUSE: bus.cp0_rdata = cause_word(cause_q);
         CP0_EPC:   bus.cp0_rdata = epc_q;
         CP0_PRID:  bus.cp0_rdata = PRID;
         default:   bus.cp0_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed vector bench for cp0_unit: each row drives stage-M inputs,
// checks req/rdata/epc_out before the edge, then lets the edge commit.
module tb_cp0_unit;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   cp0_unit_if bus();

   cp0_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          rst;
      bit          we;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] vpc;
      bit          bd;
      bit          ev;
      logic [4:0]  code;
      logic [5:0]  hw;
      bit          clr;
      bit          e_req;
      logic [31:0] e_rd;
      logic [31:0] e_epc;
   } vec_t;

   vec_t vq[$];

   localparam logic [31:0] PRID = 32'h2021_0007;

   function automatic vec_t mk(
      input bit rst, input bit we, input logic [4:0] addr,
      input logic [31:0] wdata, input logic [31:0] vpc,
      input bit bd, input bit ev, input logic [4:0] code,
      input logic [5:0] hw, input bit clr, input bit e_req,
      input logic [31:0] e_rd, input logic [31:0] e_epc);
      vec_t v;
      v.rst = rst; v.we = we; v.addr = addr; v.wdata = wdata;
      v.vpc = vpc; v.bd = bd; v.ev = ev; v.code = code;
      v.hw = hw; v.clr = clr; v.e_req = e_req;
      v.e_rd = e_rd; v.e_epc = e_epc;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      reset           = v.rst;
      bus.cp0_we      = v.we;
      bus.cp0_addr    = v.addr;
      bus.cp0_wdata   = v.wdata;
      bus.vpc         = v.vpc;
      bus.bd_in       = v.bd;
      bus.exc_valid   = v.ev;
      bus.exc_code_in = v.code;
      bus.hw_int      = v.hw;
      bus.exl_clr     = v.clr;
   endtask

   task automatic chk32(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      drive(mk(1,0,5'd0,0,0,0,1,5'd12,6'h3f,0,0,0,0));

      // reset held with an exception pending: req must stay low
      @(negedge clk);
      #2 chk32("rst_req0", {31'b0, bus.req}, 32'd0);
      @(negedge clk);
      #2 chk32("rst_req1", {31'b0, bus.req}, 32'd0);

      //          rst we addr  wdata          vpc            bd ev code   hw    clr req rdata          epc
      vq.push_back(mk(0,0,5'd12,0,            0,             0,0,5'd0, 6'h00,0, 0,32'h0,         32'h0));
      vq.push_back(mk(0,0,5'd13,0,            0,             0,0,5'd0, 6'h00,0, 0,32'h0,         32'h0));
      vq.push_back(mk(0,0,5'd14,0,            0,             0,0,5'd0, 6'h00,0, 0,32'h0,         32'h0));
      vq.push_back(mk(0,0,5'd15,0,            0,             0,0,5'd0, 6'h00,0, 0,PRID,          32'h0));
      vq.push_back(mk(0,0,5'd7, 0,            0,             0,0,5'd0, 6'h00,0, 0,32'h0,         32'h0));
      vq.push_back(mk(0,1,5'd12,32'h0000_fc01,0,             0,0,5'd0, 6'h00,0, 0,32'h0,         32'h0));
      vq.push_back(mk(0,0,5'd12,0,            0,             0,0,5'd0, 6'h00,0, 0,32'h0000_fc01, 32'h0));
      vq.push_back(mk(0,0,5'd13,0,            32'h3010,      0,1,5'd12,6'h00,0, 1,32'h0,         32'h0));
      vq.push_back(mk(0,0,5'd13,0,            32'h3010,      0,1,5'd12,6'h00,0, 0,32'h0000_0030, 32'h3010));
      vq.push_back(mk(0,0,5'd12,0,            32'h3010,      0,1,5'd12,6'h00,0, 0,32'h0000_fc03, 32'h3010));
      vq.push_back(mk(0,1,5'd12,32'h0000_0403,0,             0,0,5'd0, 6'h00,1, 0,32'h0000_fc03, 32'h3010));
      vq.push_back(mk(0,0,5'd12,0,            0,             0,0,5'd0, 6'h00,0, 0,32'h0000_0401, 32'h3010));
      vq.push_back(mk(0,0,5'd14,0,            32'h3024,      1,1,5'd10,6'h01,0, 1,32'h3010,      32'h3010));
      vq.push_back(mk(0,0,5'd13,0,            0,             0,0,5'd0, 6'h01,0, 0,32'h8000_0400, 32'h3020));
      vq.push_back(mk(0,0,5'd14,0,            0,             0,0,5'd0, 6'h01,0, 0,32'h3020,      32'h3020));
      vq.push_back(mk(0,0,5'd12,0,            0,             0,0,5'd0, 6'h00,1, 0,32'h0000_0403, 32'h3020));
      vq.push_back(mk(0,0,5'd12,0,            0,             0,0,5'd0, 6'h00,0, 0,32'h0000_0401, 32'h3020));
      vq.push_back(mk(0,1,5'd12,32'h0000_fc00,0,             0,0,5'd0, 6'h00,0, 0,32'h0000_0401, 32'h3020));
      vq.push_back(mk(0,0,5'd13,0,            0,             0,0,5'd0, 6'h3f,0, 0,32'h8000_0000, 32'h3020));
      vq.push_back(mk(0,0,5'd13,0,            0,             0,0,5'd0, 6'h3f,0, 0,32'h8000_fc00, 32'h3020));
      vq.push_back(mk(0,1,5'd12,32'h0000_0401,0,             0,0,5'd0, 6'h3f,0, 0,32'h0000_fc00, 32'h3020));
      vq.push_back(mk(0,0,5'd12,0,            32'h3040,      0,0,5'd0, 6'h3f,0, 1,32'h0000_0401, 32'h3020));
      vq.push_back(mk(0,0,5'd13,0,            0,             0,0,5'd0, 6'h00,0, 0,32'h0000_fc00, 32'h3040));
      vq.push_back(mk(0,0,5'd12,0,            0,             0,0,5'd0, 6'h00,1, 0,32'h0000_0403, 32'h3040));
      vq.push_back(mk(0,0,5'd12,0,            32'h3050,      0,1,5'd4, 6'h00,1, 1,32'h0000_0401, 32'h3040));
      vq.push_back(mk(0,0,5'd12,0,            0,             0,0,5'd0, 6'h00,0, 0,32'h0000_0403, 32'h3050));
      vq.push_back(mk(0,1,5'd14,32'hdead_beef,0,             0,0,5'd0, 6'h00,1, 0,32'h3050,      32'h3050));
      vq.push_back(mk(0,0,5'd14,0,            0,             0,0,5'd0, 6'h00,0, 0,32'hdead_beef, 32'hdead_beef));
      vq.push_back(mk(0,1,5'd13,32'hffff_ffff,0,             0,0,5'd0, 6'h00,0, 0,32'h0000_0010, 32'hdead_beef));
      vq.push_back(mk(0,0,5'd13,0,            0,             0,0,5'd0, 6'h00,0, 0,32'h0000_0010, 32'hdead_beef));
      vq.push_back(mk(0,1,5'd15,32'h0,        0,             0,0,5'd0, 6'h00,0, 0,PRID,          32'hdead_beef));
      vq.push_back(mk(0,0,5'd15,0,            0,             0,0,5'd0, 6'h00,0, 0,PRID,          32'hdead_beef));
      vq.push_back(mk(0,1,5'd7, 32'h1234,     0,             0,0,5'd0, 6'h00,0, 0,32'h0,         32'hdead_beef));
      vq.push_back(mk(0,0,5'd12,0,            0,             0,0,5'd0, 6'h00,0, 0,32'h0000_0401, 32'hdead_beef));
      vq.push_back(mk(0,0,5'd14,0,            0,             0,0,5'd0, 6'h00,0, 0,32'hdead_beef, 32'hdead_beef));
      vq.push_back(mk(0,0,5'd12,0,            32'h3008,      0,1,5'd5, 6'h00,0, 1,32'h0000_0401, 32'hdead_beef));
      vq.push_back(mk(1,0,5'd12,0,            32'h3008,      0,1,5'd5, 6'h00,0, 0,32'h0000_0403, 32'h3008));
      vq.push_back(mk(0,0,5'd12,0,            0,             0,0,5'd0, 6'h00,0, 0,32'h0,         32'h0));
      vq.push_back(mk(0,0,5'd13,0,            0,             0,0,5'd0, 6'h00,0, 0,32'h0,         32'h0));
      vq.push_back(mk(0,0,5'd14,0,            0,             1,1,5'd5, 6'h00,0, 1,32'h0,         32'h0));
      vq.push_back(mk(0,0,5'd14,0,            0,             0,0,5'd0, 6'h00,0, 0,32'hffff_fffc, 32'hffff_fffc));
      vq.push_back(mk(0,0,5'd13,0,            0,             0,0,5'd0, 6'h00,0, 0,32'h8000_0014, 32'hffff_fffc));

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         drive(vq[i]);
         #2;
         chk32($sformatf("v%0d_req", i), {31'b0, bus.req}, {31'b0, vq[i].e_req});
         chk32($sformatf("v%0d_rdata", i), bus.cp0_rdata, vq[i].e_rd);
         chk32($sformatf("v%0d_epc", i), bus.epc_out, vq[i].e_epc);
      end

      // IM=0 masks a fully asserted hw_int even with IE set
      @(negedge clk);
      drive(mk(1,0,5'd12,0,0,0,0,5'd0,6'h00,0,0,0,0));
      @(negedge clk);
      drive(mk(0,1,5'd12,32'h0000_0001,0,0,0,5'd0,6'h3f,0,0,0,0));
      @(negedge clk);
      drive(mk(0,0,5'd13,0,0,0,0,5'd0,6'h3f,0,0,0,0));
      #2;
      chk32("im0_req", {31'b0, bus.req}, 32'd0);
      chk32("im0_ip", bus.cp0_rdata, 32'h0000_fc00);
      bus.cp0_addr = 5'd12;
      #1 chk32("im0_sr", bus.cp0_rdata, 32'h0000_0001);

      @(negedge clk);
      drive(mk(0,0,5'd12,0,0,0,0,5'd0,6'h00,0,0,0,0));
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
